// File: rtl/mul_share_pkg.sv
// Shared definitions for the multiplier-sharing controller: FSM encoding,
// default widths and the timeout counter width helper.
package mul_share_pkg;

  localparam int WIDTH_DEF   = 5;
  localparam int TIMEOUT_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_RESP   = 2'd3
  } state_t;

  // Counter must hold TIMEOUT_CYCLES-1; never narrower than one bit.
  function automatic int cnt_width(input int cycles);
    return (cycles > 2) ? $clog2(cycles) : 1;
  endfunction

  localparam int TO_CNT_W_DEF = cnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/rr_arbiter2.sv
// Two-input round-robin grant. Purely combinational; the parent owns the
// pointer register and advances it when an operation retires.
module rr_arbiter2 (
  input  logic [1:0] valid,
  input  logic       ptr,
  output logic [1:0] grant
);

  // One-hot grant; the pointer only matters when both inputs request.
  always_comb begin
    grant = 2'b00;
    case (valid)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = ptr ? 2'b10 : 2'b01;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mul_share_ctrl.sv
// Shares one sequential multiplier between two requesters: round-robin grant,
// operand latch, multiplier run sequencing, timeout abort and response port.
module mul_share_ctrl
  import mul_share_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int WIDTH          = WIDTH_DEF
) (
  input  logic                 mac_clk_i,
  input  logic                 mac_reset_i,
  input  logic                 req0_valid_i,
  input  logic [WIDTH-1:0]     req0_a_i,
  input  logic [WIDTH-1:0]     req0_b_i,
  output logic                 req0_ready_o,
  input  logic                 req1_valid_i,
  input  logic [WIDTH-1:0]     req1_a_i,
  input  logic [WIDTH-1:0]     req1_b_i,
  output logic                 req1_ready_o,
  output logic                 rsp_valid_o,
  input  logic                 rsp_ready_i,
  output logic                 rsp_id_o,
  output logic [2*WIDTH-1:0]   rsp_product_o,
  output logic [WIDTH-1:0]     mul_multiplicand_o,
  output logic [WIDTH-1:0]     mul_multiplier_o,
  output logic                 mul_nreset_o,
  input  logic [2*WIDTH-1:0]   mul_result_i,
  input  logic                 mul_is_result_i,
  output logic                 timeout_o
);

  localparam int               CNT_W    = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_t               state_r;
  state_t               next_state_s;
  logic                 rr_ptr_r;
  logic                 id_r;
  logic [WIDTH-1:0]     a_r;
  logic [WIDTH-1:0]     b_r;
  logic [CNT_W-1:0]     cnt_r;
  logic                 rsp_valid_r;
  logic                 rsp_id_r;
  logic [2*WIDTH-1:0]   rsp_product_r;
  logic                 mul_nreset_r;

  logic [1:0]           grant_s;
  logic                 grant_any_s;
  logic                 capture_s;
  logic                 abort_s;
  logic                 rsp_fire_s;

  rr_arbiter2 u_arb (
    .valid ({req1_valid_i, req0_valid_i}),
    .ptr   (rr_ptr_r),
    .grant (grant_s)
  );

  // Event decode shared by the FSM and the datapath registers.
  always_comb begin
    grant_any_s = (state_r == ST_IDLE) && !mac_reset_i && (grant_s != 2'b00);
    capture_s   = (state_r == ST_RUN) && mul_is_result_i;
    abort_s     = (state_r == ST_RUN) && !mul_is_result_i && (cnt_r == CNT_LAST);
    rsp_fire_s  = (state_r == ST_RESP) && rsp_valid_r && rsp_ready_i;
  end

  // State register.
  always_ff @(posedge mac_clk_i) begin
    if (mac_reset_i) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_any_s) begin
          next_state_s = ST_LAUNCH;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_LAUNCH: next_state_s = ST_RUN;
      ST_RUN: begin
        if (capture_s) begin
          next_state_s = ST_RESP;
        end else if (abort_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RUN;
        end
      end
      ST_RESP: begin
        if (rsp_fire_s) begin
          next_state_s = ST_IDLE;
        end else begin
          next_state_s = ST_RESP;
        end
      end
      default: next_state_s = ST_IDLE;
    endcase
  end

  // Output logic: accept pulses and the abort pulse follow the current cycle.
  always_comb begin
    req0_ready_o = grant_any_s && grant_s[0];
    req1_ready_o = grant_any_s && grant_s[1];
    timeout_o    = abort_s && !mac_reset_i;
  end

  // Operand latch, run counter, response holding and round-robin pointer.
  always_ff @(posedge mac_clk_i) begin
    if (mac_reset_i) begin
      a_r           <= {WIDTH{1'b0}};
      b_r           <= {WIDTH{1'b0}};
      id_r          <= 1'b0;
      cnt_r         <= {CNT_W{1'b0}};
      rsp_valid_r   <= 1'b0;
      rsp_id_r      <= 1'b0;
      rsp_product_r <= {(2*WIDTH){1'b0}};
      rr_ptr_r      <= 1'b0;
      mul_nreset_r  <= 1'b0;
    end else begin
      if (grant_any_s) begin
        a_r  <= grant_s[1] ? req1_a_i : req0_a_i;
        b_r  <= grant_s[1] ? req1_b_i : req0_b_i;
        id_r <= grant_s[1];
      end

      if (state_r == ST_LAUNCH) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (state_r == ST_RUN) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end

      if (capture_s) begin
        rsp_valid_r   <= 1'b1;
        rsp_id_r      <= id_r;
        rsp_product_r <= mul_result_i;
      end else if (rsp_fire_s) begin
        rsp_valid_r   <= 1'b0;
      end

      // An aborted operation still hands priority to the other requester.
      if (rsp_fire_s) begin
        rr_ptr_r <= ~rsp_id_r;
      end else if (abort_s) begin
        rr_ptr_r <= ~id_r;
      end

      mul_nreset_r <= (next_state_s == ST_LAUNCH) || (next_state_s == ST_RUN);
    end
  end

  assign rsp_valid_o        = rsp_valid_r;
  assign rsp_id_o           = rsp_id_r;
  assign rsp_product_o      = rsp_product_r;
  assign mul_multiplicand_o = a_r;
  assign mul_multiplier_o   = b_r;
  assign mul_nreset_o       = mul_nreset_r;

endmodule

// File: doc/mul_share_ctrl.md
Name: mul_share_ctrl

Overview:
Controller that shares one 5x5 sequential multiplier between two requesters. It arbitrates with round-robin priority and latches the granted operands. It then sequences the multiplier's active-low restart and run signal, waits for the multiplier's result flag, and returns the 10-bit product through a valid/ready response port tagged with the requester id. It sits between the MAC front-end requesters and the multiplier instance.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in RUN before abort; must exceed the multiplier's fixed latency (6 cycles).
WIDTH, 5, operand width; product width is 2*WIDTH.

Ports:
mac_clk_i  in  1  single clock, rising edge
mac_reset_i  in  1  synchronous, active-high reset
req0_valid_i  in  1  requester 0 has operands
req0_a_i  in  WIDTH  requester 0 multiplicand
req0_b_i  in  WIDTH  requester 0 multiplier
req0_ready_o  out  1  requester 0 accepted this cycle
req1_valid_i, req1_a_i, req1_b_i, req1_ready_o  as above, requester 1
rsp_valid_o  out  1  product available
rsp_ready_i  in  1  consumer accepts product
rsp_id_o  out  1  requester that owns the product
rsp_product_o  out  2*WIDTH  product
mul_multiplicand_o  out  WIDTH  to multiplier, held stable from LAUNCH to capture
mul_multiplier_o  out  WIDTH  to multiplier, held stable from LAUNCH to capture
mul_nreset_o  out  1  active-low run/restart to multiplier
mul_result_i  in  2*WIDTH  multiplier product
mul_is_result_i  in  1  multiplier product valid flag
timeout_o  out  1  one-cycle pulse on abort

Behaviour:
- Interface: one clock, mac_clk_i. Reset mac_reset_i is synchronous and active-high.
- Reset values:
  - state=IDLE, mul_nreset_o=0, operand regs=0.
  - rsp_valid_o=0, rsp_id_o=0, rsp_product_o=0.
  - req*_ready_o=0, timeout_o=0.
  - rr pointer=0, meaning requester 0 has priority.
- State machine (IDLE, LAUNCH, RUN, RESP):
  - IDLE:
    - mul_nreset_o=0.
    - If any valid is high, grant one: a single requester wins outright; if both are valid, the rr pointer decides.
    - Pulse the winner's ready_o high for exactly that cycle (combinational from state and valids).
    - Latch its operands and id, then go to LAUNCH.
  - LAUNCH:
    - mul_nreset_o=1 for one cycle so the multiplier fetches the operands.
    - Clear the timeout counter, then go to RUN.
  - RUN:
    - mul_nreset_o=1; the timeout counter increments.
    - On mul_is_result_i=1: capture mul_result_i into rsp_product_o, set rsp_valid_o=1, drive mul_nreset_o=0 from the next cycle, and go to RESP.
    - If the counter reaches TIMEOUT_CYCLES-1 with no result: pulse timeout_o, drop mul_nreset_o, and go to IDLE. No response is produced, and the rr pointer still advances.
  - RESP:
    - mul_nreset_o=0; hold rsp_* stable while rsp_ready_i=0.
    - On rsp_valid_o & rsp_ready_i: clear rsp_valid_o, set rr pointer to ~rsp_id_o, and go to IDLE.
- Throughput: at most one operation in flight. No new grant is made while in LAUNCH, RUN or RESP, so ready_o stays 0 in those states.
- Latency: from grant (IDLE cycle) to rsp_valid_o is 1 (LAUNCH) + multiplier latency + 1 capture cycle.
- mul_is_result_i is ignored outside RUN. A spurious flag in IDLE or RESP has no effect.
- The product is unsigned, 2*WIDTH bits, passed through unmodified. Width is never truncated.
- Simultaneous events:
  - Requesters may change valid or operands freely after their ready pulse; the latched copies are used.
  - If mac_reset_i is asserted in any state, including mid-RUN, the next state is IDLE, mul_nreset_o=0, and any pending response is discarded.
- Requesters are not required to hold valid high. A deasserted valid simply loses arbitration.

Decomposition:
- Shared package mul_share_pkg: state encoding constants (IDLE=2'd0, LAUNCH=2'd1, RUN=2'd2, RESP=2'd3), WIDTH default, and the timeout counter width as clog2(TIMEOUT_CYCLES).
- One natural sub-module, rr_arbiter2: two-input round-robin grant with a pointer input and a one-hot grant output. It is combinational, with the pointer register kept in the parent.
- The multiplier itself is instantiated at top level, not inside this block.

Test Plan:
- Single request: req0 a=7, b=9 with a behavioural multiplier model -> req0_ready_o pulses 1 cycle; rsp_valid_o with rsp_product_o=63, rsp_id_o=0; mul_nreset_o low after capture.
- Max operands: req1 a=31, b=31 -> rsp_product_o=961, rsp_id_o=1; a=0, b=31 -> 0.
- Contention: both valid from reset, held for 3 operations with req0 (3x4) and req1 (5x6) -> grant order 0,1,0; products 12, 30, 12; no grant while busy.
- Backpressure: rsp_ready_i=0 for 5 cycles after rsp_valid_o -> product and id stable, no new ready_o pulse, mul_nreset_o=0 throughout.
- Timeout: model never raises mul_is_result_i -> timeout_o pulses exactly at RUN cycle TIMEOUT_CYCLES-1; state IDLE; no rsp_valid_o; next grant goes to the other requester.
- Reset mid-RUN: assert mac_reset_i during RUN for 1 cycle -> next cycle all outputs at reset values; a subsequent request 2x3 returns 6.
